// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: Moore FSM sequencing fetch, decode and
// per-instruction execute/write-back steps for lw, sw, R-type, beq and j.
// Optional addi support is compiled in when MULTICYCLE_CTRL_ADDI_EN is defined.
//
//   state  | meaning
//   IDLE   | post-reset cycle, everything quiet
//   FETCH  | read instruction, load IR, PC <= PC + 4
//   DECODE | read registers, precompute branch target into ALUOut
//   MEMADR | compute load/store address
//   MEMRD  | read data memory at ALUOut
//   MEMWB  | write loaded word to rt
//   MEMWR  | write B to data memory at ALUOut
//   EXEC   | R-type ALU operation
//   RWB    | write ALU result to rd
//   BEQ    | compare, take branch when zero
//   JUMP   | PC <= jump address
//   ADDIEX | A + immediate (addi builds only)
//   ADDIWB | write ALU result to rt (addi builds only)
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10
`ifdef MULTICYCLE_CTRL_ADDI_EN
    ,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
`endif
  } state_t;

  state_t cur_state, nxt_state;

  assign state = cur_state;

  // State register; reset lands in IDLE immediately, even mid-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Next-state and output decode; unlisted codes fall to all-zero and FETCH.
  always_comb begin
    nxt_state = S_FETCH;
    pc_en     = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    PCSource  = 2'b00;
    ALUOp     = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    case (cur_state)
      S_IDLE: nxt_state = S_FETCH;
      S_FETCH: begin
        MemRead   = 1'b1;
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b01;
        pc_en     = 1'b1;
        nxt_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_RTYPE:       nxt_state = S_EXEC;
          OP_LW, OP_SW:   nxt_state = S_MEMADR;
          OP_BEQ:         nxt_state = S_BEQ;
          OP_J:           nxt_state = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:        nxt_state = S_ADDIEX;
`endif
          default:        nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nxt_state = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        pc_en    = zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        pc_en    = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
`endif
      default: nxt_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequences followed by
// random opcodes, checked against a per-instruction state-path model and a
// per-state control table. Honours MULTICYCLE_CTRL_ADDI_EN like the design.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic [14:0] outs;

  int checks = 0;
  int passed = 0;
  int exp_q[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .RegDst(RegDst), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

  // Control word each state must present, written from the instruction view.
  function automatic logic [14:0] exp_out(input int s, input logic z);
    logic pe, iord, mr, mw, irw, m2r, asa, rw, rd;
    logic [1:0] pcs, aop, asb;
    pe = 0; iord = 0; mr = 0; mw = 0; irw = 0; m2r = 0; asa = 0; rw = 0; rd = 0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (s)
      1:      begin mr = 1; irw = 1; asb = 2'b01; pe = 1; end
      2:      asb = 2'b11;
      3, 11:  begin asa = 1; asb = 2'b10; end
      4:      begin mr = 1; iord = 1; end
      5:      begin rw = 1; m2r = 1; end
      6:      begin mw = 1; iord = 1; end
      7:      begin asa = 1; aop = 2'b10; end
      8:      begin rw = 1; rd = 1; end
      9:      begin asa = 1; aop = 2'b01; pcs = 2'b01; pe = z; end
      10:     begin pcs = 2'b10; pe = 1; end
      12:     rw = 1;
      default: ;
    endcase
    return {pe, iord, mr, mw, irw, m2r, pcs, aop, asa, asb, rw, rd};
  endfunction

  // Expected state path of one instruction, FETCH through its last state.
  function automatic void plan(input logic [5:0] o);
    exp_q = {};
    exp_q.push_back(1);
    exp_q.push_back(2);
    case (o)
      6'b100011: begin exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5); end
      6'b101011: begin exp_q.push_back(3); exp_q.push_back(6); end
      6'b000000: begin exp_q.push_back(7); exp_q.push_back(8); end
      6'b000100: exp_q.push_back(9);
      6'b000010: exp_q.push_back(10);
`ifdef MULTICYCLE_CTRL_ADDI_EN
      6'b001000: begin exp_q.push_back(11); exp_q.push_back(12); end
`endif
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: drive at falling edge, compare 1ns later. zmode<0 randomizes zero.
  task automatic step(input int s, input int zmode, input bit set_op, input logic [5:0] o);
    @(negedge clk);
    if (set_op) op = o;
    zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    #1;
    check("state", 32'(state), 32'(s));
    check("outputs", 32'(outs), 32'(exp_out(s, zero)));
  endtask

  task automatic run(input logic [5:0] o, input int zmode);
    plan(o);
    foreach (exp_q[i]) step(exp_q[i], zmode, i == 0, o);
  endtask

  initial begin
    logic [5:0] ops[7];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};

    // Reset held: IDLE with everything low, then release before an edge.
    @(negedge clk); #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;

    run(6'b100011, -1);
    run(6'b000100, 1);
    run(6'b000100, 0);
    run(6'b000000, -1);
    run(6'b101011, -1);
    run(6'b001000, -1);
    run(6'b111111, -1);

    // Asynchronous reset in the middle of MEMRD.
    plan(6'b100011);
    for (int i = 0; i < 4; i++) step(exp_q[i], -1, i == 0, 6'b100011);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_outs", 32'(outs), 32'd0);
    @(negedge clk); #1;
    check("rst_hold_state", 32'(state), 32'd0);
    check("rst_hold_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;

    run(6'b000010, -1);

    for (int n = 0; n < 60; n++) begin
      int idx;
      logic [5:0] o;
      idx = $urandom_range(0, 7);
      o = (idx == 7) ? 6'($urandom) : ops[idx];
      run(o, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port `op`, input, 6 bits: opcode field, instruction bits [31:26], taken from the instruction register.
REQ-004 The block SHALL have port `zero`, input, 1 bit: ALU zero flag.
REQ-005 The block SHALL have port `pc_en`, output, 1 bit: PC register write enable, with branch condition already applied.
REQ-006 The block SHALL have port `IorD`, output, 1 bit: memory address select (0=PC, 1=ALUOut).
REQ-007 The block SHALL have port `MemRead`, output, 1 bit: memory read strobe.
REQ-008 The block SHALL have port `MemWrite`, output, 1 bit: memory write strobe.
REQ-009 The block SHALL have port `IRWrite`, output, 1 bit: instruction register load enable.
REQ-010 The block SHALL have port `MemtoReg`, output, 1 bit: write-back data select (0=ALUOut, 1=MDR).
REQ-011 The block SHALL have port `PCSource`, output, 2 bits: next-PC select (00=ALU result, 01=ALUOut, 10=jump address).
REQ-012 The block SHALL have port `ALUOp`, output, 2 bits: ALU operation class (00=add, 01=sub, 10=funct-decoded).
REQ-013 The block SHALL have port `ALUSrcA`, output, 1 bit: ALU A-operand select (0=PC, 1=A register).
REQ-014 The block SHALL have port `ALUSrcB`, output, 2 bits: ALU B-operand select (00=B, 01=4, 10=sign-extended immediate, 11=shifted sign-extended immediate).
REQ-015 The block SHALL have port `RegWrite`, output, 1 bit: register file write enable.
REQ-016 The block SHALL have port `RegDst`, output, 1 bit: destination register select (0=rt, 1=rd).
REQ-017 The block SHALL have port `state`, output, 4 bits: current state code, for debug.

Function
REQ-018 The block SHALL be a Moore FSM whose outputs are combinational decodes of the state register only, except `pc_en` in BEQ, which also depends on `zero`.
REQ-019 State codes SHALL be: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BEQ=9, JUMP=10, ADDIEX=11, ADDIWB=12; codes 13-15 SHALL be unused.
REQ-020 Every output SHALL be 0 in every state unless set otherwise by REQ-021 to REQ-032.
REQ-021 In FETCH, outputs SHALL be MemRead=1, IRWrite=1, ALUSrcB=01, PCSource=00, pc_en=1.
REQ-022 In DECODE, ALUSrcB SHALL be 11 (branch target precomputed into ALUOut).
REQ-023 In MEMADR and in ADDIEX, outputs SHALL be ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-024 In MEMRD, outputs SHALL be MemRead=1, IorD=1.
REQ-025 In MEMWB, outputs SHALL be RegWrite=1, MemtoReg=1, RegDst=0.
REQ-026 In MEMWR, outputs SHALL be MemWrite=1, IorD=1.
REQ-027 In EXEC, outputs SHALL be ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-028 In RWB, outputs SHALL be RegWrite=1, RegDst=1, MemtoReg=0.
REQ-029 In BEQ, outputs SHALL be ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, and pc_en equal to `zero`.
REQ-030 In JUMP, outputs SHALL be PCSource=10, pc_en=1.
REQ-031 In ADDIWB, outputs SHALL be RegWrite=1, RegDst=0, MemtoReg=0.
REQ-032 In IDLE, all outputs SHALL be 0.
REQ-033 State transitions SHALL be as follows:
- IDLE goes to FETCH.
- FETCH goes to DECODE.
- From DECODE, `op` is sampled once and selects the next state:
  - 000000 goes to EXEC.
  - 100011 goes to MEMADR.
  - 101011 goes to MEMADR.
  - 000100 goes to BEQ.
  - 000010 goes to JUMP.
  - 001000 goes to ADDIEX.
  - Any other opcode goes to FETCH.
REQ-034 Further transitions SHALL be as follows:
- From MEMADR, op=100011 goes to MEMRD; otherwise MEMWR.
- MEMRD goes to MEMWB.
- EXEC goes to RWB.
- ADDIEX goes to ADDIWB.
- MEMWB, MEMWR, RWB, BEQ, JUMP and ADDIWB go to FETCH.
REQ-035 Instruction latency SHALL be counted from FETCH to the last state inclusive:
- lw: 5 cycles.
- R-type, sw, addi: 4 cycles.
- beq, j: 3 cycles.
- unsupported opcode: 2 cycles, with no architectural write.
REQ-036 An unused state code, if entered, SHALL drive all outputs to 0 and transition to FETCH on the next edge.
REQ-037 `zero` SHALL be ignored in every state other than BEQ.

Reset
REQ-038 Assertion of `rst_n`=0 SHALL force state to IDLE immediately, without waiting for a clock edge, including mid-instruction, and all outputs SHALL read 0 while reset is held.
REQ-039 The first rising edge of `clk` after `rst_n` deasserts SHALL move the FSM from IDLE to FETCH, so exactly one all-zero cycle follows reset.

Configuration
REQ-040 The macro `MULTICYCLE_CTRL_ADDI_EN` SHALL control addi support.
- Defined: op=001000 SHALL follow DECODE, then ADDIEX, then ADDIWB, as specified above.
- Undefined: states ADDIEX and ADDIWB SHALL be absent; op=001000 SHALL be treated as unsupported (DECODE goes to FETCH); codes 11 and 12 SHALL behave per REQ-036.

Verification
REQ-041 Bench SHALL cover reset with op=100011: the state sequence is 0,1,2,3,4,5,1; MemRead=1 in states 1 and 4; IorD=1 in state 4; RegWrite=MemtoReg=1 in state 5 only.
REQ-042 Bench SHALL cover op=000100: with zero=1 in BEQ, pc_en=1 and PCSource=01; repeated with zero=0, pc_en=0; both cases return to FETCH after 3 cycles.
REQ-043 Bench SHALL cover op=000000: states 1,2,7,8; ALUOp=10 in EXEC; RegWrite=RegDst=1 in RWB.
REQ-044 Bench SHALL cover op=101011: states 1,2,3,6; MemWrite=1 and IorD=1 in MEMWR; RegWrite stays 0 throughout.
REQ-045 Bench SHALL cover `rst_n` pulsed low asynchronously during MEMRD: state=0 and all outputs 0 before the next edge; FETCH on the first edge after release.
REQ-046 Bench SHALL cover op=001000 in both builds: with the macro, states 1,2,11,12 and RegWrite=1 in state 12; without it, states 1,2,1 and no write enables asserted.
